// File: rtl/tape_turbo_loader_pkg.sv
// tape_pkg: shared constants and types for the tape turbo loader.
//   OP_*      : stub opcodes overlaid on the ROM data bus
//   tl_state_e: loader state (IDLE / TURBO / FALLBACK)
package tape_pkg;

   localparam logic [7:0] OP_JR      = 8'h18;  // JR e
   localparam logic [7:0] OP_JR_SELF = 8'hFE;  // JR operand that spins on itself
   localparam logic [7:0] OP_LD_L    = 8'h2E;  // LD L,n
   localparam logic [7:0] OP_NOP     = 8'h00;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TURBO    = 2'd1,
      FALLBACK = 2'd2
   } tl_state_e;

endpackage

// File: rtl/tape_turbo_loader_if.sv
// tape_src_if: byte stream from the tape buffer reader into the loader.
//   src_valid/src_data/src_last : source byte and end-of-block tag
//   src_ready                   : loader can accept a byte
interface tape_src_if;
   logic       src_valid;
   logic [7:0] src_data;
   logic       src_last;
   logic       src_ready;

   modport master (output src_valid, src_data, src_last, input  src_ready);
   modport slave  (input  src_valid, src_data, src_last, output src_ready);
endinterface

// File: rtl/tape_turbo_loader_fifo.sv
// tape_byte_fifo: synchronous FIFO holding {last, data} tape bytes.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_push, i_din    : write strobe and word (caller guarantees legality)
//   i_pop            : advance head (caller guarantees non-empty)
//   o_dout           : head word, valid while !o_empty
//   o_full, o_empty  : occupancy flags
module tape_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 9
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]  r_wr, r_rd;
   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   // A push while full is only issued together with a pop; the write lands
   // in the slot whose contents are being read out this same cycle.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
   end

   assign o_dout  = r_mem[r_rd[AW-1:0]];
   assign o_empty = (r_wr == r_rd);
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/tape_turbo_loader.sv
// tape_turbo_loader: ROM-trap fast loader. Traps M1 fetches in the ROM tape
// routine and overlays a stub that feeds tape bytes from a prefetch FIFO.
//   clk_sys, reset_n      : clock, asynchronous active-low reset
//   src (tape_src_if)     : tape byte stream in, src_ready = FIFO not full
//   enable                : turbo allowed
//   addr, m1, rom_en      : CPU fetch address, M1 level, ROM mapped
//   turbo, fallback       : overlay active / starvation timeout fired
//   dout_en, dout         : ROM data bus override and overlay byte
//   block_xor, block_cnt  : checksum of last block, blocks completed
//   led                   : stretched activity indicator
module tape_turbo_loader
   import tape_pkg::*;
#(
   parameter logic [15:0] ENTRY_ADDR = 16'h0562,
   parameter logic [15:0] WIN_LO     = 16'h053F,
   parameter logic [15:0] WIN_HI     = 16'h0605,
   parameter logic [15:0] STUB_BASE  = 16'h05CA,
   parameter int          STUB_LEN   = 14,
   parameter logic [15:0] ZERO_LO    = 16'h056C,
   parameter logic [15:0] ZERO_HI    = 16'h058F,
   parameter int          FIFO_DEPTH = 8,
   parameter int          TIMEOUT_W  = 20,
   parameter int          LED_W      = 22
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   tape_src_if.slave   src,
   input  logic        enable,
   input  logic [15:0] addr,
   input  logic        m1,
   input  logic        rom_en,
   output logic        turbo,
   output logic        dout_en,
   output logic [7:0]  dout,
   output logic        fallback,
   output logic [7:0]  block_xor,
   output logic [7:0]  block_cnt,
   output logic        led
);
   // 17-bit bounds so STUB_BASE+STUB_LEN cannot wrap.
   localparam logic [16:0] STUB_END = {1'b0, STUB_BASE} + 17'(STUB_LEN);
   localparam logic [16:0] GO_CLR   = {1'b0, STUB_BASE} + 17'd2;

   tl_state_e              r_state, w_state_nxt;
   logic                   r_m1;
   logic [7:0]             r_data;
   logic                   r_go;
   logic [TIMEOUT_W-1:0]   r_tmo;
   logic [7:0]             r_run;
   logic [7:0]             r_bxor;
   logic [7:0]             r_bcnt;
   logic [LED_W-1:0]       r_led;

   logic        w_m1_edge, w_in_win, w_in_stub, w_in_zero, w_sat;
   logic        w_handoff, w_pop, w_push, w_full, w_empty;
   logic [8:0]  w_head;
   logic [15:0] w_stub_off;

   assign w_m1_edge  = m1 & ~r_m1;
   assign w_in_win   = rom_en && (addr >= WIN_LO) && (addr < WIN_HI);
   assign w_in_stub  = (addr >= STUB_BASE) && ({1'b0, addr} < STUB_END);
   assign w_in_zero  = (addr >= ZERO_LO) && (addr < ZERO_HI);
   assign w_stub_off = addr - STUB_BASE;
   assign w_sat      = &r_tmo;

   assign w_handoff = w_m1_edge && (r_state == TURBO) && (addr == STUB_BASE);
   assign w_pop     = w_handoff && !w_empty;
   // When full, a push is still taken alongside a pop so the level holds;
   // src_ready deliberately stays low in that cycle.
   assign w_push    = src.src_valid && (!w_full || w_pop);
   assign src.src_ready = !w_full;

   tape_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
      .i_clk   (clk_sys),
      .i_rst_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   ({src.src_last, src.src_data}),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state and state outputs
   always_comb begin
      w_state_nxt = r_state;
      turbo       = 1'b0;
      fallback    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_m1_edge && addr == ENTRY_ADDR && rom_en && enable)
               w_state_nxt = TURBO;
         end
         TURBO: begin
            turbo = 1'b1;
            if (w_m1_edge && !w_in_win) w_state_nxt = IDLE;
            else if (w_sat)             w_state_nxt = FALLBACK;
         end
         FALLBACK: begin
            fallback = 1'b1;
            if (w_m1_edge && !w_in_win) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Overlay. The stub's JR at offset 0 either falls through (operand 0x00)
   // or spins on itself (0xFE) until a byte is ready.
   always_comb begin
      dout_en = 1'b0;
      dout    = OP_NOP;
      if (r_state == TURBO && rom_en) begin
         if (w_in_stub) begin
            dout_en = 1'b1;
            case (w_stub_off)
               16'd0:   dout = OP_JR;
               16'd1:   dout = r_go ? OP_NOP : OP_JR_SELF;
               16'd2:   dout = OP_LD_L;
               16'd3:   dout = r_data;
               default: dout = OP_NOP;
            endcase
         end else if (w_in_zero) begin
            dout_en = 1'b1;
         end
      end
   end

   // M1 tracking, byte handoff and go flag
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_m1   <= 1'b0;
         r_data <= 8'hFF;
         r_go   <= 1'b0;
      end else begin
         r_m1 <= m1;
         if (w_handoff) begin
            r_go <= !w_empty;
            if (!w_empty) r_data <= w_head[7:0];
         end else if (w_m1_edge && ({1'b0, addr} >= GO_CLR || !w_in_win)) begin
            r_go <= 1'b0;
         end
      end
   end

   // Starvation counter: only runs while the stub is spinning with nothing queued.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                          r_tmo <= '0;
      else if (r_state != TURBO || w_pop)    r_tmo <= '0;
      else if (w_empty && !r_go && !w_sat)   r_tmo <= r_tmo + 1'b1;
   end

   // Block checksum/count and LED stretch
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_run  <= 8'h00;
         r_bxor <= 8'h00;
         r_bcnt <= 8'h00;
         r_led  <= '0;
      end else begin
         if (w_pop) begin
            r_led <= '1;
            if (w_head[8]) begin
               r_bxor <= r_run ^ w_head[7:0];
               r_run  <= 8'h00;
               r_bcnt <= r_bcnt + 8'd1;
            end else begin
               r_run  <= r_run ^ w_head[7:0];
            end
         end else if (r_led != '0) begin
            r_led <= r_led - 1'b1;
         end
      end
   end

   assign block_xor = r_bxor;
   assign block_cnt = r_bcnt;
   assign led       = (r_led != '0);

endmodule

// File: tb/tb_tape_turbo_loader.sv
module tb_tape_turbo_loader;
   localparam int          TW    = 8;
   localparam int          LW    = 4;
   localparam int          DEPTH = 8;
   localparam logic [15:0] ENTRY = 16'h0562;
   localparam logic [15:0] STUB  = 16'h05CA;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable, m1, rom_en;
   logic [15:0] addr;
   logic        turbo, dout_en, fallback, led;
   logic [7:0]  dout, block_xor, block_cnt;

   always #5 clk_sys = ~clk_sys;

   tape_src_if sif ();

   tape_turbo_loader #(
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT_W  (TW),
      .LED_W      (LW)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .src       (sif),
      .enable    (enable),
      .addr      (addr),
      .m1        (m1),
      .rom_en    (rom_en),
      .turbo     (turbo),
      .dout_en   (dout_en),
      .dout      (dout),
      .fallback  (fallback),
      .block_xor (block_xor),
      .block_cnt (block_cnt),
      .led       (led)
   );

   int         checks = 0;
   int         errors = 0;
   logic [8:0] sb_q[$];
   logic [7:0] m_run, m_xor, m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      chk("push_ready", sif.src_ready, 1);
      sif.src_valid = 1'b1;
      sif.src_data  = d;
      sif.src_last  = l;
      tick();
      sif.src_valid = 1'b0;
      sb_q.push_back({l, d});
   endtask

   task automatic fetch(input logic [15:0] a);
      addr = a;
      m1   = 1'b1;
      tick();
      tick();
      m1 = 1'b0;
      tick();
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      chk({tag, "_en"}, dout_en, 1);
      chk(tag, dout, exp);
   endtask

   task automatic model_pop(input logic [8:0] e);
      m_run = m_run ^ e[7:0];
      if (e[8]) begin
         m_xor = m_run;
         m_run = 8'h00;
         m_cnt = m_cnt + 8'd1;
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [8:0] e;
      chk({tag, "_sbq"}, (sb_q.size() != 0), 1);
      e = sb_q.pop_front();
      fetch(STUB);
      rd({tag, "_go"}, STUB + 16'd1, 8'h00);
      rd(tag, STUB + 16'd3, e[7:0]);
      model_pop(e);
      chk({tag, "_xor"}, block_xor, m_xor);
      chk({tag, "_cnt"}, block_cnt, m_cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [8:0] e;
      enable = 1'b1; m1 = 1'b0; rom_en = 1'b1; addr = STUB + 16'd3;
      sif.src_valid = 1'b0; sif.src_data = 8'h00; sif.src_last = 1'b0;
      m_run = 8'h00; m_xor = 8'h00; m_cnt = 8'h00;

      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_turbo", turbo, 0);
      chk("rst_fallback", fallback, 0);
      chk("rst_dout_en", dout_en, 0);
      chk("rst_dout", dout, 0);
      chk("rst_src_ready", sif.src_ready, 1);
      chk("rst_bxor", block_xor, 0);
      chk("rst_bcnt", block_cnt, 0);
      chk("rst_led", led, 0);
      reset_n = 1'b1;
      tick();

      // T1: prefetched byte delivered through the stub
      push(8'h3C, 1'b1);
      fetch(ENTRY);
      chk("t1_turbo", turbo, 1);
      pop_chk("t1_pop");
      rd("t1_jr", STUB, 8'h18);
      rd("t1_ldl", STUB + 16'd2, 8'h2E);
      rd("t1_tail", STUB + 16'd5, 8'h00);
      rd("t1_zero", 16'h0570, 8'h00);
      addr = 16'h0600; #1;
      chk("t1_nooverlay", dout_en, 0);
      rom_en = 1'b0; addr = STUB + 16'd3; #1;
      chk("t1_romoff", dout_en, 0);
      rom_en = 1'b1;

      // T2: starvation leads to fallback
      fetch(STUB);
      rd("t2_spin", STUB + 16'd1, 8'hFE);
      chk("t2_turbo", turbo, 1);
      n = 0;
      while (fallback !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      chk("t2_fallback", fallback, 1);
      chk("t2_time", (n >= (1 << TW) - 4) && (n <= (1 << TW) + 2), 1);
      chk("t2_turbo_off", turbo, 0);
      chk("t2_dout_en", dout_en, 0);
      fetch(ENTRY);
      chk("t2_entry_ign_fb", fallback, 1);
      chk("t2_entry_ign_tb", turbo, 0);
      fetch(16'h1234);
      chk("t2_idle_fb", fallback, 0);
      chk("t2_idle_tb", turbo, 0);

      // T3: block checksum and count
      fetch(ENTRY);
      chk("t3_turbo", turbo, 1);
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      push(8'h03, 1'b1);
      pop_chk("t3_b1");
      pop_chk("t3_b2");
      pop_chk("t3_b3");
      chk("t3_bxor0", block_xor, 8'h00);
      push(8'hAA, 1'b1);
      pop_chk("t3_aa");
      chk("t3_bxorAA", block_xor, 8'hAA);
      chk("t3_led_on", led, 1);
      repeat ((1 << LW) + 4) tick();
      chk("t3_led_off", led, 0);

      // T4: full FIFO, simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i), 1'b0);
      chk("t4_full", sif.src_ready, 0);
      addr = STUB; m1 = 1'b1;
      sif.src_valid = 1'b1; sif.src_data = 8'h77; sif.src_last = 1'b1;
      tick();
      sif.src_valid = 1'b0;
      tick();
      m1 = 1'b0;
      tick();
      e = sb_q.pop_front();
      sb_q.push_back({1'b1, 8'h77});
      rd("t4_oldest", STUB + 16'd3, e[7:0]);
      model_pop(e);
      chk("t4_still_full", sif.src_ready, 0);
      for (int i = 0; i < DEPTH; i++) pop_chk("t4_drain");
      chk("t4_drained", sif.src_ready, 1);

      // T5: leaving the window, entry with enable low
      chk("t5_turbo", turbo, 1);
      fetch(16'h1234);
      chk("t5_exit", turbo, 0);
      enable = 1'b0;
      fetch(ENTRY);
      chk("t5_disabled", turbo, 0);
      enable = 1'b1;

      // T6: reset mid-block
      fetch(ENTRY);
      push(8'h55, 1'b0);
      pop_chk("t6_pre");
      push(8'h66, 1'b0);
      push(8'h77, 1'b0);
      addr = STUB + 16'd3;
      @(posedge clk_sys);
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6_turbo", turbo, 0);
      chk("t6_fallback", fallback, 0);
      chk("t6_dout_en", dout_en, 0);
      chk("t6_dout", dout, 0);
      chk("t6_src_ready", sif.src_ready, 1);
      chk("t6_bxor", block_xor, 0);
      chk("t6_bcnt", block_cnt, 0);
      chk("t6_led", led, 0);
      sb_q.delete();
      m_run = 8'h00; m_xor = 8'h00; m_cnt = 8'h00;
      tick();
      reset_n = 1'b1;
      tick();
      fetch(ENTRY);
      fetch(STUB);
      rd("t6_datareg", STUB + 16'd3, 8'hFF);
      rd("t6_spin", STUB + 16'd1, 8'hFE);
      push(8'h10, 1'b1);
      pop_chk("t6_post");
      chk("t6_post_bxor", block_xor, 8'h10);
      chk("t6_post_bcnt", block_cnt, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
